issue_select_arbiter: RTL
=========================

// Module: issue_select_arbiter
// PURPOSE
//  Wakeup/select scheduler between the issue queue and the functional units.
//  Each cycle it picks at most one ready queue entry per FU, using per-FU round-robin priority.
//  It returns the grant to the FUs and a one-hot clear vector to the issue queue.
//  It tracks multi-cycle FU occupancy, so an occupied unit is never granted.
// PARAMETERS
//  NUM_INSTRUCTIONS    64  issue queue entries; index width IDX_W = $clog2(NUM_INSTRUCTIONS)
//  NUM_FUNCTIONAL_UNITS 3  FUs arbitrated; FU id width 2 (supports up to 3 FUs + id 3 = none)
//  FU2_LATENCY          3  occupancy cycles of FU2 (multiplier), >=1; FU0/FU1 fixed at 1
//  STAT_W              32  width of optional statistics counters
// PORTS
//  clk              in   1                      rising-edge clock
//  reset            in   1                      asynchronous, active-high
//  flush            in   1                      synchronous squash (branch mispredict)
//  entry_ready      in   NUM_INSTRUCTIONS       entry valid and both operands available
//  entry_fu_sel     in   2*NUM_INSTRUCTIONS     per-entry target FU id; entry i at [2i+1:2i]; 3 = none
//  fu_accept        in   NUM_FUNCTIONAL_UNITS   FU k can take an op this cycle
//  grant_valid      out  NUM_FUNCTIONAL_UNITS   registered grant to FU k
//  grant_idx        out  IDX_W*NUM_FUNCTIONAL_UNITS  granted entry for FU k at [IDX_W*k +: IDX_W]
//  issue_clear      out  NUM_INSTRUCTIONS       one-hot per grant; queue invalidates those entries
//  fu_busy          out  NUM_FUNCTIONAL_UNITS   FU k occupied by a multi-cycle op
//  stat_grants      out  STAT_W                 ISSUE_STATS_EN only: total grants
//  stat_stall_cyc   out  STAT_W                 ISSUE_STATS_EN only: cycles with a ready entry but zero grants
// BEHAVIOUR
//  Reset (async):
//   - grant_valid, issue_clear and fu_busy are 0; grant_idx is 0.
//   - rr_ptr[k] = 0 for all k; busy counters and statistics are 0.
//  Candidates for FU k:
//   - entry_ready[i] && entry_fu_sel[i]==k && !issue_clear[i].
//   - The registered issue_clear masks entries granted last cycle that the queue has not yet removed.
//  Select:
//   - Lowest i with i >= rr_ptr[k]; if none, wrap and take the lowest i < rr_ptr[k].
//   - Entries with fu_sel==3, or an FU id >= NUM_FUNCTIONAL_UNITS, are never granted.
//  Grant condition at posedge:
//   - fu_accept[k] && !fu_busy[k] && a candidate exists && !flush.
//   - Then grant_valid[k]<=1, grant_idx[k]<=i, issue_clear[i]<=1, rr_ptr[k]<=(i+1) mod NUM_INSTRUCTIONS.
//   - Otherwise grant_valid[k]<=0 and rr_ptr[k] holds.
//  Timing and ownership:
//   - Latency is exactly 1 cycle from candidate visible to grant_valid; outputs are valid for one cycle.
//   - Entries are disjoint per FU, so each issue_clear bit has at most one owner.
//   - Up to 3 bits of issue_clear may be set in one cycle.
//  FU2 occupancy (FU2_LATENCY>1):
//   - On an FU2 grant, busy_cnt <= FU2_LATENCY-1 and fu_busy[2] <= 1.
//   - While busy_cnt != 0 it decrements; fu_busy[2] falls in the same edge the counter reaches 0.
//   - Back-to-back FU2 grants are therefore spaced FU2_LATENCY cycles apart.
//   - With FU2_LATENCY==1, fu_busy[2] stays 0.
//   - fu_busy[0] and fu_busy[1] are constant 0.
//  flush:
//   - Next edge clears grant_valid, issue_clear, busy_cnt and fu_busy.
//   - rr_ptr is held; statistics are held, and the flush cycle is not counted.
//  Other boundaries:
//   - All entries ready for one FU: strict rotation, with no entry starved beyond NUM_INSTRUCTIONS grants.
//   - Pointer at NUM_INSTRUCTIONS-1 with a grant there: rr_ptr wraps to 0.
//   - fu_accept low: no grant and no pointer change; the candidate stays pending.
//   - Reset asserted mid-operation: all state clears immediately, whatever the clock phase.
// CONFIGURATION
//  ISSUE_STATS_EN defined:
//   - stat_grants += popcount(grant decisions) each edge.
//   - stat_stall_cyc += 1 when any entry_ready is set and no grant is issued.
//   - Both counters saturate at all-ones and are cleared by reset only.
//  ISSUE_STATS_EN undefined:
//   - stat_* ports are absent; no counter logic.
// TESTING
//  1. Reset, then entry_ready[5]=1, fu_sel[5]=0, fu_accept=3'b111
//     -> next cycle grant_valid=3'b001, grant_idx0=5, issue_clear=1<<5, rr_ptr0=6.
//  2. Entries 2 and 40 ready for FU1, held ready for 3 cycles
//     -> grants idx 2, then 40, then 2; no entry granted on consecutive cycles.
//  3. Entries 10, 11, 12 for FU0, FU1, FU2 together -> one cycle with grant_valid=3'b111, idx 10/11/12.
//  4. FU2_LATENCY=3, FU2 entries 7 and 8 always ready -> grants at cycles t and t+3; fu_busy[2]=1 for t+1..t+2.
//  5. rr_ptr1 at 63 with entries 63 and 0 ready for FU1 -> grant 63, then 0 (wrap).
//  6. flush while FU2 is busy -> next cycle fu_busy=0 and grant_valid=0.
//     With ISSUE_STATS_EN, a ready entry with fu_accept=0 for 4 cycles gives stat_stall_cyc=4.

Source files
------------

// File: rtl/issue_select_arbiter_if.sv
// Bus between the issue queue / FUs (master) and the select arbiter (slave).
// The stat_* signals exist only when ISSUE_STATS_EN is defined.
interface issue_select_arbiter_if #(
  parameter int unsigned NUM_INSTRUCTIONS     = 64,
  parameter int unsigned NUM_FUNCTIONAL_UNITS = 3,
  parameter int unsigned STAT_W               = 32
);
  localparam int unsigned IDX_W = $clog2(NUM_INSTRUCTIONS);

  logic                                  flush;
  logic [NUM_INSTRUCTIONS-1:0]           entry_ready;
  logic [2*NUM_INSTRUCTIONS-1:0]         entry_fu_sel;
  logic [NUM_FUNCTIONAL_UNITS-1:0]       fu_accept;
  logic [NUM_FUNCTIONAL_UNITS-1:0]       grant_valid;
  logic [IDX_W*NUM_FUNCTIONAL_UNITS-1:0] grant_idx;
  logic [NUM_INSTRUCTIONS-1:0]           issue_clear;
  logic [NUM_FUNCTIONAL_UNITS-1:0]       fu_busy;
`ifdef ISSUE_STATS_EN
  logic [STAT_W-1:0]                     stat_grants;
  logic [STAT_W-1:0]                     stat_stall_cyc;

  modport master (
    output flush, entry_ready, entry_fu_sel, fu_accept,
    input  grant_valid, grant_idx, issue_clear, fu_busy, stat_grants, stat_stall_cyc
  );

  modport slave (
    input  flush, entry_ready, entry_fu_sel, fu_accept,
    output grant_valid, grant_idx, issue_clear, fu_busy, stat_grants, stat_stall_cyc
  );
`else
  modport master (
    output flush, entry_ready, entry_fu_sel, fu_accept,
    input  grant_valid, grant_idx, issue_clear, fu_busy
  );

  modport slave (
    input  flush, entry_ready, entry_fu_sel, fu_accept,
    output grant_valid, grant_idx, issue_clear, fu_busy
  );
`endif
endinterface

// File: rtl/issue_select_arbiter.sv
// Wakeup/select scheduler: one ready issue-queue entry per FU per cycle, per-FU round-robin,
// with FU2 multi-cycle occupancy tracking. Statistics counters built when ISSUE_STATS_EN is defined.
module issue_select_arbiter #(
  parameter int unsigned NUM_INSTRUCTIONS     = 64,
  parameter int unsigned NUM_FUNCTIONAL_UNITS = 3,
  parameter int unsigned FU2_LATENCY          = 3,
  parameter int unsigned STAT_W               = 32
) (
  input logic                   clk,
  input logic                   reset,
  issue_select_arbiter_if.slave io_bus
);
  localparam int unsigned IDX_W = $clog2(NUM_INSTRUCTIONS);
  localparam int unsigned NF    = NUM_FUNCTIONAL_UNITS;
  localparam int unsigned CNT_W = $clog2(FU2_LATENCY + 1);

  logic [NF-1:0]               r_grant_valid;
  logic [IDX_W-1:0]            r_grant_idx [NF];
  logic [IDX_W-1:0]            r_rr_ptr    [NF];
  logic [NUM_INSTRUCTIONS-1:0] r_issue_clear;
  logic [CNT_W-1:0]            r_busy_cnt;
  logic                        r_fu2_busy;

  logic [NUM_INSTRUCTIONS-1:0] w_cand [NF];
  logic [NF-1:0]               w_found_hi;
  logic [NF-1:0]               w_found_lo;
  logic [NF-1:0]               w_grant;
  logic [NF-1:0]               w_fu_busy;
  logic [IDX_W-1:0]            w_sel_hi  [NF];
  logic [IDX_W-1:0]            w_sel_lo  [NF];
  logic [IDX_W-1:0]            w_sel     [NF];
  logic [IDX_W-1:0]            w_ptr_nxt [NF];
  logic [NUM_INSTRUCTIONS-1:0] w_clear_d;
  logic                        w_fu2_grant;
  logic [CNT_W-1:0]            w_busy_cnt_d;

  // Scan high-to-low so the last hit is the lowest index, both above the pointer and overall.
  // FU ids are 2 bits wide, so at most three units (id 3 = none) can be arbitrated.
  always_comb begin
    w_clear_d  = '0;
    w_found_hi = '0;
    w_found_lo = '0;
    w_grant    = '0;
    for (int k = 0; k < int'(NF); k++) begin
      w_cand[k]    = '0;
      w_sel_hi[k]  = '0;
      w_sel_lo[k]  = '0;
      for (int i = int'(NUM_INSTRUCTIONS) - 1; i >= 0; i--) begin
        w_cand[k][i] = io_bus.entry_ready[i] && !r_issue_clear[i] &&
                       (io_bus.entry_fu_sel[2*i +: 2] == 2'(k));
        if (w_cand[k][i]) begin
          w_found_lo[k] = 1'b1;
          w_sel_lo[k]   = IDX_W'(i);
          if (IDX_W'(i) >= r_rr_ptr[k]) begin
            w_found_hi[k] = 1'b1;
            w_sel_hi[k]   = IDX_W'(i);
          end
        end
      end
      w_sel[k]     = w_found_hi[k] ? w_sel_hi[k] : w_sel_lo[k];
      w_ptr_nxt[k] = (w_sel[k] == IDX_W'(NUM_INSTRUCTIONS - 1)) ? '0 : w_sel[k] + IDX_W'(1);
      w_grant[k]   = io_bus.fu_accept[k] && !w_fu_busy[k] && w_found_lo[k] && !io_bus.flush;
      if (w_grant[k]) begin
        w_clear_d[w_sel[k]] = 1'b1;
      end
    end
  end

  if (NF > 2) begin : g_fu2
    assign w_fu2_grant = w_grant[2];
  end else begin : g_no_fu2
    assign w_fu2_grant = 1'b0;
  end

  always_comb begin
    w_busy_cnt_d = r_busy_cnt;
    if (io_bus.flush) begin
      w_busy_cnt_d = '0;
    end else if (w_fu2_grant) begin
      w_busy_cnt_d = CNT_W'(FU2_LATENCY - 1);
    end else if (r_busy_cnt != '0) begin
      w_busy_cnt_d = r_busy_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_valid <= '0;
      r_issue_clear <= '0;
      r_busy_cnt    <= '0;
      r_fu2_busy    <= 1'b0;
      for (int k = 0; k < int'(NF); k++) begin
        r_grant_idx[k] <= '0;
        r_rr_ptr[k]    <= '0;
      end
    end else begin
      r_grant_valid <= w_grant;
      r_issue_clear <= w_clear_d;
      r_busy_cnt    <= w_busy_cnt_d;
      // Busy drops on the same edge the counter reaches zero.
      r_fu2_busy    <= (w_busy_cnt_d != '0);
      for (int k = 0; k < int'(NF); k++) begin
        if (w_grant[k]) begin
          r_grant_idx[k] <= w_sel[k];
          r_rr_ptr[k]    <= w_ptr_nxt[k];
        end
      end
    end
  end

  assign io_bus.grant_valid = r_grant_valid;
  assign io_bus.issue_clear = r_issue_clear;
  assign io_bus.fu_busy     = w_fu_busy;

  for (genvar k = 0; k < int'(NF); k++) begin : g_fu
    assign io_bus.grant_idx[IDX_W*k +: IDX_W] = r_grant_idx[k];
    if (k == 2) begin : g_busy
      assign w_fu_busy[k] = r_fu2_busy;
    end else begin : g_single
      assign w_fu_busy[k] = 1'b0;
    end
  end

`ifdef ISSUE_STATS_EN
  localparam int unsigned SUM_W = STAT_W + 1;

  logic [STAT_W-1:0] r_stat_grants;
  logic [STAT_W-1:0] r_stat_stall;
  logic [SUM_W-1:0]  w_grant_sum;

  assign w_grant_sum = {1'b0, r_stat_grants} + SUM_W'($countones(w_grant));

  // Saturating counters; a flush cycle is neither a grant nor a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_grants <= '0;
      r_stat_stall  <= '0;
    end else if (!io_bus.flush) begin
      r_stat_grants <= w_grant_sum[STAT_W] ? '1 : w_grant_sum[STAT_W-1:0];
      if ((|io_bus.entry_ready) && (w_grant == '0) && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + STAT_W'(1);
      end
    end
  end

  assign io_bus.stat_grants    = r_stat_grants;
  assign io_bus.stat_stall_cyc = r_stat_stall;
`endif

endmodule
